// File: rtl/wb_stage_lq.sv
// Writeback stage: registered EX/WB slot for non-memory results plus an in-order pending-memory queue (LQ).
// Latency: OTHER writes RF one cycle after acceptance; LOAD/STORE retire in the cycle the LSU responds.
// Backpressure: ex_ready_o drops for OTHER while the LQ is non-empty and for memory ops while the LQ is full.
// Optional feature macro: WB_PERF_CNT_EN adds minstret_o / mcompressed_o retire counters.
module wb_stage_lq #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int LQ_DEPTH   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ex_valid_i,
    output logic                          ex_ready_o,
    input  logic [1:0]                    ex_type_i,
    input  logic [REG_ADDR_W-1:0]         ex_rf_waddr_i,
    input  logic [DATA_W-1:0]             ex_rf_wdata_i,
    input  logic                          ex_rf_we_i,
    input  logic [PC_W-1:0]               ex_pc_i,
    input  logic                          ex_compressed_i,
    input  logic                          ex_perf_count_i,
    input  logic                          lsu_resp_valid_i,
    input  logic                          lsu_resp_err_i,
    input  logic [DATA_W-1:0]             lsu_rdata_i,
    output logic                          rf_we_o,
    output logic [REG_ADDR_W-1:0]         rf_waddr_o,
    output logic [DATA_W-1:0]             rf_wdata_o,
    output logic                          retire_o,
    output logic                          retire_compressed_o,
    output logic [PC_W-1:0]               retire_pc_o,
    output logic                          lsu_err_o,
    output logic [$clog2(LQ_DEPTH):0]     lq_count_o,
    output logic                          idle_o
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0]                   minstret_o,
    output logic [31:0]                   mcompressed_o
`endif
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic                  we;
        logic [PC_W-1:0]       pc;
        logic                  comp;
        logic                  perf;
    } lq_ent_t;

    // EX/WB slot for non-memory instructions
    logic                  slot_vld_q,   slot_vld_d;
    logic                  slot_we_q,    slot_we_d;
    logic [REG_ADDR_W-1:0] slot_waddr_q, slot_waddr_d;
    logic [DATA_W-1:0]     slot_wdata_q, slot_wdata_d;
    logic [PC_W-1:0]       slot_pc_q,    slot_pc_d;
    logic                  slot_comp_q,  slot_comp_d;
    logic                  slot_perf_q,  slot_perf_d;

    // Pending memory queue
    lq_ent_t               lq_q [LQ_DEPTH];
    lq_ent_t               lq_d [LQ_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic    is_mem, is_load, accept, push, pop, pop_ok, pop_err;
    lq_ent_t head;

    // Handshake and queue control; type 3 decodes as OTHER
    always_comb begin
        is_load = (ex_type_i == 2'd1);
        is_mem  = is_load || (ex_type_i == 2'd2);
        if (rst_i) begin
            ex_ready_o = 1'b1;
        end else if (is_mem) begin
            ex_ready_o = (count_q < CNT_W'(LQ_DEPTH));
        end else begin
            ex_ready_o = (count_q == '0);
        end
        accept  = ex_valid_i && ex_ready_o && !rst_i;
        push    = accept && is_mem;
        pop     = lsu_resp_valid_i && (count_q != '0) && !rst_i;
        pop_ok  = pop && !lsu_resp_err_i;
        pop_err = pop && lsu_resp_err_i;
        head    = lq_q[rd_ptr_q];
    end

    // Next-state for slot, queue storage, pointers and occupancy
    always_comb begin
        slot_vld_d   = accept && !is_mem;
        slot_we_d    = ex_rf_we_i;
        slot_waddr_d = ex_rf_waddr_i;
        slot_wdata_d = ex_rf_wdata_i;
        slot_pc_d    = ex_pc_i;
        slot_comp_d  = ex_compressed_i;
        slot_perf_d  = ex_perf_count_i;

        lq_d     = lq_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            lq_d[wr_ptr_q] = '{waddr: ex_rf_waddr_i, we: ex_rf_we_i && is_load, pc: ex_pc_i,
                               comp: ex_compressed_i, perf: ex_perf_count_i};
            wr_ptr_d = (wr_ptr_q == PTR_W'(LQ_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(LQ_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // RF write and retire outputs; slot and LQ pop are mutually exclusive by construction
    always_comb begin
        rf_we_o             = 1'b0;
        rf_waddr_o          = '0;
        rf_wdata_o          = '0;
        retire_o            = 1'b0;
        retire_compressed_o = 1'b0;
        retire_pc_o         = '0;
        lsu_err_o           = 1'b0;
        if (!rst_i && slot_vld_q) begin
            rf_we_o             = slot_we_q;
            rf_waddr_o          = slot_we_q ? slot_waddr_q : '0;
            rf_wdata_o          = slot_we_q ? slot_wdata_q : '0;
            retire_o            = slot_perf_q;
            retire_compressed_o = slot_perf_q && slot_comp_q;
            retire_pc_o         = slot_pc_q;
        end else if (pop) begin
            retire_pc_o = head.pc;
            lsu_err_o   = pop_err;
            if (pop_ok) begin
                rf_we_o             = head.we;
                rf_waddr_o          = head.we ? head.waddr : '0;
                rf_wdata_o          = head.we ? lsu_rdata_i : '0;
                retire_o            = head.perf;
                retire_compressed_o = head.perf && head.comp;
            end
        end
        lq_count_o = rst_i ? '0 : count_q;
        idle_o     = rst_i || (!slot_vld_q && (count_q == '0));
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_vld_q   <= 1'b0;
            slot_we_q    <= 1'b0;
            slot_waddr_q <= '0;
            slot_wdata_q <= '0;
            slot_pc_q    <= '0;
            slot_comp_q  <= 1'b0;
            slot_perf_q  <= 1'b0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_we_q    <= slot_we_d;
            slot_waddr_q <= slot_waddr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_pc_q    <= slot_pc_d;
            slot_comp_q  <= slot_comp_d;
            slot_perf_q  <= slot_perf_d;
            lq_q         <= lq_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [63:0] minstret_q, minstret_d;
    logic [31:0] mcomp_q,    mcomp_d;

    // Retire counters, wrapping silently
    always_comb begin
        minstret_d = minstret_q + (retire_o ? 64'd1 : 64'd0);
        mcomp_d    = mcomp_q + (retire_compressed_o ? 32'd1 : 32'd0);
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            minstret_q <= '0;
            mcomp_q    <= '0;
        end else begin
            minstret_q <= minstret_d;
            mcomp_q    <= mcomp_d;
        end
    end

    assign minstret_o    = minstret_q;
    assign mcompressed_o = mcomp_q;
`endif

endmodule

// File: tb/tb_wb_stage_lq.sv
module tb_wb_stage_lq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [1:0]  ex_type_i;
    logic [4:0]  ex_rf_waddr_i;
    logic [31:0] ex_rf_wdata_i;
    logic        ex_rf_we_i;
    logic [31:0] ex_pc_i;
    logic        ex_compressed_i;
    logic        ex_perf_count_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [31:0] lsu_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        retire_o;
    logic        retire_compressed_o;
    logic [31:0] retire_pc_o;
    logic        lsu_err_o;
    logic [1:0]  lq_count_o;
    logic        idle_o;
`ifdef WB_PERF_CNT_EN
    logic [63:0] minstret_o;
    logic [31:0] mcompressed_o;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    wb_stage_lq #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32), .LQ_DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_type_i(ex_type_i),
        .ex_rf_waddr_i(ex_rf_waddr_i), .ex_rf_wdata_i(ex_rf_wdata_i), .ex_rf_we_i(ex_rf_we_i),
        .ex_pc_i(ex_pc_i), .ex_compressed_i(ex_compressed_i), .ex_perf_count_i(ex_perf_count_i),
        .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i), .lsu_rdata_i(lsu_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .retire_o(retire_o), .retire_compressed_o(retire_compressed_o), .retire_pc_o(retire_pc_o),
        .lsu_err_o(lsu_err_o), .lq_count_o(lq_count_o), .idle_o(idle_o)
`ifdef WB_PERF_CNT_EN
        , .minstret_o(minstret_o), .mcompressed_o(mcompressed_o)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [4:0] a, input logic [31:0] d,
                         input logic we, input logic [31:0] pc, input logic comp, input logic perf);
        ex_valid_i      = v;
        ex_type_i       = t;
        ex_rf_waddr_i   = a;
        ex_rf_wdata_i   = d;
        ex_rf_we_i      = we;
        ex_pc_i         = pc;
        ex_compressed_i = comp;
        ex_perf_count_i = perf;
    endtask

    task automatic resp(input logic v, input logic e, input logic [31:0] d);
        lsu_resp_valid_i = v;
        lsu_resp_err_i   = e;
        lsu_rdata_i      = d;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, 2'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0);
        resp(0, 0, 32'd0);
        tick;
        tick;
        settle;
        check_val("rst_ready", ex_ready_o, 1);
        check_val("rst_idle", idle_o, 1);
        check_val("rst_we", rf_we_o, 0);
        check_val("rst_retire", retire_o, 0);
        check_val("rst_count", lq_count_o, 0);
        rst_i = 1'b0;
        tick;

        // OTHER: write one cycle after acceptance
        drive(1, 2'd0, 5'd5, 32'hDEADBEEF, 1, 32'h40, 0, 1);
        settle;
        check_val("oth_ready", ex_ready_o, 1);
        tick;
        drive(0, 2'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0);
        settle;
        check_val("oth_we", rf_we_o, 1);
        check_val("oth_waddr", rf_waddr_o, 5);
        check_val("oth_wdata", rf_wdata_o, 32'hDEADBEEF);
        check_val("oth_retire", retire_o, 1);
        check_val("oth_pc", retire_pc_o, 32'h40);
        check_val("oth_busy", idle_o, 0);
        tick;
        settle;
        check_val("oth_idle", idle_o, 1);
        check_val("oth_we_off", rf_we_o, 0);

        // LOAD blocks a following OTHER until its response
        drive(1, 2'd1, 5'd7, 32'd0, 1, 32'h100, 0, 1);
        settle;
        check_val("ld_ready", ex_ready_o, 1);
        tick;
        drive(1, 2'd0, 5'd9, 32'h55, 1, 32'h104, 0, 1);
        settle;
        check_val("ld_blk_ready", ex_ready_o, 0);
        check_val("ld_count", lq_count_o, 1);
        check_val("ld_no_we", rf_we_o, 0);
        tick;
        settle;
        check_val("ld_blk_ready2", ex_ready_o, 0);
        resp(1, 0, 32'h1234);
        settle;
        check_val("ld_rsp_ready", ex_ready_o, 0);
        check_val("ld_rsp_we", rf_we_o, 1);
        check_val("ld_rsp_waddr", rf_waddr_o, 7);
        check_val("ld_rsp_wdata", rf_wdata_o, 32'h1234);
        check_val("ld_rsp_retire", retire_o, 1);
        check_val("ld_rsp_pc", retire_pc_o, 32'h100);
        tick;
        resp(0, 0, 32'd0);
        settle;
        check_val("ld_after_ready", ex_ready_o, 1);
        check_val("ld_after_count", lq_count_o, 0);
        tick;
        drive(0, 2'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0);
        settle;
        check_val("oth2_we", rf_we_o, 1);
        check_val("oth2_waddr", rf_waddr_o, 9);
        check_val("oth2_wdata", rf_wdata_o, 32'h55);
        tick;

        // Three STOREs against a two-entry LQ
        drive(1, 2'd2, 5'd1, 32'd0, 1, 32'h200, 0, 1);
        tick;
        tick;
        settle;
        check_val("st_full_count", lq_count_o, 2);
        check_val("st_full_ready", ex_ready_o, 0);
        tick;
        settle;
        check_val("st_held_count", lq_count_o, 2);
        check_val("st_no_we", rf_we_o, 0);
        resp(1, 0, 32'hCAFE);
        settle;
        check_val("st_pop_ready", ex_ready_o, 0);
        check_val("st_pop_retire", retire_o, 1);
        check_val("st_pop_we", rf_we_o, 0);
        check_val("st_pop_wdata", rf_wdata_o, 0);
        tick;
        resp(0, 0, 32'd0);
        settle;
        check_val("st_one_count", lq_count_o, 1);
        check_val("st_one_ready", ex_ready_o, 1);
        tick;
        drive(0, 2'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0);
        settle;
        check_val("st_refill_count", lq_count_o, 2);
        resp(1, 0, 32'd0);
        tick;
        tick;
        resp(0, 0, 32'd0);
        settle;
        check_val("st_drain_count", lq_count_o, 0);

        // LOAD with bus error
        drive(1, 2'd1, 5'd3, 32'd0, 1, 32'h300, 0, 1);
        tick;
        drive(0, 2'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0);
        resp(1, 1, 32'hFFFF);
        settle;
        check_val("err_flag", lsu_err_o, 1);
        check_val("err_pc", retire_pc_o, 32'h300);
        check_val("err_we", rf_we_o, 0);
        check_val("err_retire", retire_o, 0);
        check_val("err_waddr", rf_waddr_o, 0);
        tick;
        resp(0, 0, 32'd0);
        settle;
        check_val("err_count", lq_count_o, 0);
        check_val("err_clear", lsu_err_o, 0);

        // Response with empty LQ is dropped
        resp(1, 0, 32'hAA);
        settle;
        check_val("empty_we", rf_we_o, 0);
        check_val("empty_retire", retire_o, 0);
        check_val("empty_err", lsu_err_o, 0);
        tick;
        resp(0, 0, 32'd0);
        settle;
        check_val("empty_count", lq_count_o, 0);

        // Reset with two pending loads
        drive(1, 2'd1, 5'd4, 32'd0, 1, 32'h500, 0, 1);
        tick;
        tick;
        drive(0, 2'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0);
        settle;
        check_val("pre_rst_count", lq_count_o, 2);
        rst_i = 1'b1;
        settle;
        check_val("mid_rst_count", lq_count_o, 0);
        check_val("mid_rst_ready", ex_ready_o, 1);
        tick;
        rst_i = 1'b0;
        resp(1, 0, 32'h77);
        settle;
        check_val("post_rst_we", rf_we_o, 0);
        check_val("post_rst_retire", retire_o, 0);
        check_val("post_rst_idle", idle_o, 1);
        tick;
        resp(0, 0, 32'd0);
        settle;
        check_val("post_rst_count", lq_count_o, 0);
`ifdef WB_PERF_CNT_EN
        check_val("perf_rst_inst", minstret_o, 0);
        check_val("perf_rst_comp", mcompressed_o, 0);
`endif

        // Back-to-back OTHERs: five counted (two compressed), then one uncounted
        for (int i = 0; i < 6; i++) begin
            drive(1, 2'd0, 5'(10 + i), 32'(i), 1, 32'h400 + 32'(4 * i), (i == 1) || (i == 3) || (i == 5), i < 5);
            if (i > 0) begin
                settle;
                check_val("b2b_retire", retire_o, 1);
            end
            tick;
        end
        drive(0, 2'd0, 5'd0, 32'd0, 0, 32'd0, 0, 0);
        settle;
        check_val("nocount_we", rf_we_o, 1);
        check_val("nocount_retire", retire_o, 0);
        check_val("nocount_comp", retire_compressed_o, 0);
        tick;
        settle;
`ifdef WB_PERF_CNT_EN
        check_val("perf_inst", minstret_o, 5);
        check_val("perf_comp", mcompressed_o, 2);
`endif
        check_val("final_idle", idle_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/wb_stage_lq.md
Name: wb_stage_lq

Overview:
- Parametrised writeback stage with an in-order pending-memory queue (LQ) and a registered EX/WB slot.
- Accepts instructions from EX with a valid/ready handshake.
- Non-memory results write the register file (RF) one cycle after acceptance. Loads and stores park in the LQ until the LSU responds, then retire in order.
- Sits between the EX stage / LSU and the RF write port; drives retire and performance-count strobes.

Parameters:
- DATA_W, 32, RF data width
- REG_ADDR_W, 5, RF address width
- PC_W, 32, PC width
- LQ_DEPTH, 2, maximum outstanding memory ops; power of 2, range 1..8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  EX offers an instruction
- ex_ready_o  out  1  stage accepts; transfer = ex_valid_i & ex_ready_o
- ex_type_i  in  2  0=OTHER, 1=LOAD, 2=STORE; 3 is treated as OTHER
- ex_rf_waddr_i  in  REG_ADDR_W  destination register
- ex_rf_wdata_i  in  DATA_W  EX result (OTHER only)
- ex_rf_we_i  in  1  instruction writes RF
- ex_pc_i  in  PC_W  instruction PC
- ex_compressed_i  in  1  16-bit instruction
- ex_perf_count_i  in  1  counts toward retire statistics
- lsu_resp_valid_i  in  1  LSU completes the oldest memory op
- lsu_resp_err_i  in  1  that response is a bus error
- lsu_rdata_i  in  DATA_W  load data
- rf_we_o  out  1  RF write strobe
- rf_waddr_o  out  REG_ADDR_W  RF write address
- rf_wdata_o  out  DATA_W  RF write data
- retire_o  out  1  one instruction retired this cycle (counted)
- retire_compressed_o  out  1  retired instruction was compressed
- retire_pc_o  out  PC_W  PC of the retiring or erroring instruction
- lsu_err_o  out  1  memory op completed with error
- lq_count_o  out  $clog2(LQ_DEPTH)+1  LQ occupancy
- idle_o  out  1  slot empty and LQ empty

Behaviour:
- Reset: slot invalid, LQ empty (pointers 0, count 0). All registered state cleared.
  - All outputs are 0 during and after reset, except ex_ready_o = 1 and idle_o = 1.
  - Reset mid-operation discards all pending entries; no write or retire is issued for them.
- ex_ready_o is combinational, not dependent on lsu_resp_valid_i:
  - OTHER: ready = (lq_count == 0).
  - LOAD/STORE: ready = (lq_count < LQ_DEPTH).
- OTHER accepted in cycle N:
  - Slot loads the payload; the slot is valid in N+1 only.
  - In N+1: rf_we_o = ex_rf_we_i, waddr/wdata from the slot.
  - retire_o = perf_count, retire_compressed_o = perf_count & compressed, retire_pc_o = slot PC.
  - Back-to-back OTHER gives 1 retire per cycle, full throughput.
- LOAD/STORE accepted: push {waddr, we & LOAD, pc, compressed, perf_count} at the tail. The entry does not write or retire on acceptance.
- LSU response pops the head in the same cycle; the response is valid no earlier than the cycle after the push.
  - No error: rf_we_o = head.we, rf_wdata_o = lsu_rdata_i, retire_o = head.perf.
  - Error: rf_we_o = 0, retire_o = 0, lsu_err_o = 1, retire_pc_o = head PC.
- Response with empty LQ: dropped; no write, no retire, no error.
- Simultaneous push and pop: count unchanged. A push when full is blocked by ex_ready_o even if a pop occurs that cycle.
- Ordering: OTHER is accepted only with the LQ empty, so the slot and an LQ pop never drive the RF in the same cycle. Retirement is strictly in program order.
- Pointers wrap modulo LQ_DEPTH. lq_count_o is exact.
- rf_waddr_o and rf_wdata_o are 0 whenever rf_we_o = 0. Outputs are combinational from the slot/head/LSU and must be glitch-tolerant at the RF only.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- When defined, adds outputs minstret_o (64) and mcompressed_o (32).
  - Both increment on retire_o and on retire_compressed_o respectively.
  - Both clear on rst_i.
  - Both wrap silently.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- OTHER, rd=x5, data 0xDEADBEEF, we=1, perf=1, accepted at cycle 1 -> cycle 2: rf_we_o=1, waddr=5, wdata=0xDEADBEEF, retire_o=1; cycle 3: idle_o=1.
- LOAD rd=x7 pc=0x100, then OTHER offered -> ex_ready_o=0 for the OTHER until a response with rdata 0x1234; that cycle rf_wdata_o=0x1234, waddr=7; the OTHER is accepted the next cycle.
- LQ_DEPTH=2: three back-to-back STOREs with no response -> lq_count_o=2, ex_ready_o=0 for the third; one response -> count 1, third accepted next cycle, count 2.
- LOAD with lsu_resp_err_i=1 -> lsu_err_o=1, retire_pc_o=load PC, rf_we_o=0, retire_o=0, LQ pops.
- lsu_resp_valid_i with empty LQ -> no write, retire or error; rst_i asserted with 2 pending -> count 0, a later response is ignored.
- WB_PERF_CNT_EN: 5 retires with 2 compressed -> minstret_o=5, mcompressed_o=2; a perf=0 retire leaves both unchanged.
